sfp_array: RTL

- Parametrised special-function/accumulation stage that sits between the output FIFO of a corelet and the PSUM SRAM write path.
- Supports two modes, selected per operation:
  - WS: accumulates partial sums across kernel passes into an addressable on-chip buffer, then drains it.
  - OS: forwards finished sums from the MAC array through a one-deep output register.
- Generalises the fixed-width, fixed-mode SFP bank with configurable depth, saturating arithmetic, a valid/ready handshake and a drain sequencer.

---
 rtl/sfp_array_if.sv | 40 ++++
 rtl/sfp_array.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sfp_array_if.sv
// sfp_array_if: input/output handshake, mode/relu controls and status of the sfp_array stage.
// ovf_cnt exists only when SFP_OVF_COUNT_EN is defined.
interface sfp_array_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 4
);
  logic                     mode;
  logic                     relu_en;
  logic                     in_valid;
  logic                     in_ready;
  logic [psum_bw*col-1:0]   in_data;
  logic [addr_bw-1:0]       in_addr;
  logic                     drain_start;
  logic                     out_valid;
  logic                     out_ready;
  logic [psum_bw*col-1:0]   out_data;
  logic [addr_bw-1:0]       out_addr;
  logic                     busy;
  logic                     ovf;
`ifdef SFP_OVF_COUNT_EN
  logic [15:0]              ovf_cnt;
`endif

  modport master (
    output mode, relu_en, in_valid, in_data, in_addr, drain_start, out_ready,
    input  in_ready, out_valid, out_data, out_addr, busy, ovf
`ifdef SFP_OVF_COUNT_EN
    , input ovf_cnt
`endif
  );

  modport slave (
    input  mode, relu_en, in_valid, in_data, in_addr, drain_start, out_ready,
    output in_ready, out_valid, out_data, out_addr, busy, ovf
`ifdef SFP_OVF_COUNT_EN
    , output ovf_cnt
`endif
  );
endinterface

// File: rtl/sfp_array.sv
// sfp_array: WS saturating accumulate buffer with drain sequencer, or OS one-deep pass register (optional SFP_OVF_COUNT_EN).
// Latency 1 cycle in->out (PASS) / first drain word 1 cycle after DRAIN entry; out_ready stalls drain and holds output, in_ready low in DRAIN or on a stalled PASS output.
module sfp_array #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int addr_bw = 4
) (
  input logic        clk,
  input logic        reset,
  sfp_array_if.slave bus
);
  localparam int dw = psum_bw * col;

  typedef enum logic [1:0] {IDLE, ACCUM, PASS, DRAIN} state_t;

  state_t             state, state_nxt;
  logic               mode_q;
  logic               ready_en;
  logic [depth-1:0]   ent_vld;
  logic [dw-1:0]      buf_mem [depth];

  logic               in_rdy;
  logic               in_fire, out_fire;
  logic               acc_we, pass_ld, drain_ld, drain_end;
  logic [addr_bw-1:0] drain_idx;

  logic               out_valid_q, ovf_q;
  logic [dw-1:0]      out_data_q;
  logic [addr_bw-1:0] out_addr_q;

  logic [dw-1:0]      buf_rd, acc_dat, ld_src, ld_dat;
  logic               hit;
  logic [col-1:0]     clamp;

  // ready_en keeps in_ready low until the first edge after reset release
  always_comb begin
    in_rdy = 1'b0;
    case (state)
      IDLE, ACCUM: in_rdy = ready_en;
      PASS:        in_rdy = !out_valid_q || bus.out_ready;
      default:     in_rdy = 1'b0;
    endcase
  end

  assign in_fire  = bus.in_valid && in_rdy;
  assign out_fire = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_we    = 1'b0;
    pass_ld   = 1'b0;
    drain_ld  = 1'b0;
    drain_end = 1'b0;
    drain_idx = '0;
    case (state)
      IDLE: begin
        acc_we  = in_fire && !bus.mode;
        // a drain request takes priority over starting a pass-through
        pass_ld = in_fire && bus.mode && !bus.drain_start;
        if (bus.drain_start)  state_nxt = DRAIN;
        else if (in_fire)     state_nxt = bus.mode ? PASS : ACCUM;
      end
      ACCUM: begin
        acc_we = in_fire && !mode_q;
        if (bus.drain_start) state_nxt = DRAIN;
      end
      PASS: begin
        pass_ld = in_fire;
        if (!out_valid_q && !bus.in_valid) state_nxt = IDLE;
      end
      DRAIN: begin
        if (!out_valid_q) begin
          drain_ld  = 1'b1;
          drain_idx = '0;
        end else if (bus.out_ready) begin
          if (out_addr_q == addr_bw'(depth - 1)) begin
            drain_end = 1'b1;
            state_nxt = IDLE;
          end else begin
            drain_ld  = 1'b1;
            drain_idx = out_addr_q + addr_bw'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign buf_rd = buf_mem[bus.in_addr];
  assign hit    = ent_vld[bus.in_addr];
  assign ld_src = pass_ld ? bus.in_data : (ent_vld[drain_idx] ? buf_mem[drain_idx] : '0);

  for (genvar c = 0; c < col; c++) begin : g_ch
    logic [psum_bw-1:0] a, b, v;
    logic [psum_bw:0]   s;
    assign a = buf_rd[c*psum_bw +: psum_bw];
    assign b = bus.in_data[c*psum_bw +: psum_bw];
    assign s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    // overflow when the two top bits of the widened sum disagree
    assign clamp[c] = hit && (s[psum_bw] ^ s[psum_bw-1]);
    assign acc_dat[c*psum_bw +: psum_bw] =
        !hit     ? b :
        clamp[c] ? (s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}}) :
                   s[psum_bw-1:0];
    assign v = ld_src[c*psum_bw +: psum_bw];
    assign ld_dat[c*psum_bw +: psum_bw] = (bus.relu_en && v[psum_bw-1]) ? '0 : v;
  end

  always_ff @(posedge clk) begin
    if (acc_we) buf_mem[bus.in_addr] <= acc_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= 1'b0;
      ready_en    <= 1'b0;
      ent_vld     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (state == IDLE) mode_q <= bus.mode;
      if (acc_we) begin
        ent_vld[bus.in_addr] <= 1'b1;
        if (|clamp) ovf_q <= 1'b1;
      end
      if (pass_ld || drain_ld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ld_dat;
        out_addr_q  <= pass_ld ? '0 : drain_idx;
      end else if (drain_end || (state == PASS && out_fire)) begin
        out_valid_q <= 1'b0;
      end
      if (drain_end) begin
        ent_vld <= '0;
        ovf_q   <= 1'b0;
      end
    end
  end

`ifdef SFP_OVF_COUNT_EN
  localparam int cw = $clog2(col + 1);
  logic [cw-1:0] clamp_cnt;
  logic [16:0]   cnt_sum;
  logic [15:0]   ovf_cnt_q;

  always_comb begin
    clamp_cnt = '0;
    for (int i = 0; i < col; i++) clamp_cnt = clamp_cnt + cw'(clamp[i]);
  end

  assign cnt_sum = {1'b0, ovf_cnt_q} + 17'(clamp_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         ovf_cnt_q <= '0;
    else if (drain_end) ovf_cnt_q <= '0;
    else if (acc_we)    ovf_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign bus.ovf_cnt = ovf_cnt_q;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.busy      = (state != IDLE);
  assign bus.ovf       = ovf_q;
endmodule
